// File: rtl/fp_multiplier_pipe_if.sv
// Operand/result handshake bundle for fp_multiplier_pipe.
// The master drives operands and out_ready; the slave is the multiplier.
interface fp_multiplier_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, input_a, input_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, input_a, input_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-754 multiplier: classify, multiply, normalise/round/pack.
// All stages advance together; a stalled output register freezes the whole pipe.
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                 clk,
  input logic                 reset_n,
  fp_multiplier_pipe_if.slave bus
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_S     = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX_S  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE_S  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO_S = (EXP_W+2)'(0);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] ZERO_MAG = {(W-1){1'b0}};

  typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

  logic en_s;

  logic [EXP_W-1:0] exp_a_s, exp_b_s;
  logic [MAN_W-1:0] frac_a_s, frac_b_s;
  logic zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s, snan_a_s, snan_b_s;
  kind_t kind_s;
  logic  invalid_s;
  logic signed [EXP_W+1:0] exp_sum_s;

  logic                    s1_valid_r, s1_sign_r, s1_invalid_r;
  logic signed [EXP_W+1:0] s1_exp_r;
  logic [MAN_W:0]          s1_man_a_r, s1_man_b_r;
  kind_t                   s1_kind_r;

  logic                    s2_valid_r, s2_sign_r, s2_invalid_r;
  logic signed [EXP_W+1:0] s2_exp_r;
  logic [PW-1:0]           s2_prod_r;
  kind_t                   s2_kind_r;

  logic [MAN_W:0]          mant_s;
  logic [MAN_W+1:0]        mant_rnd_s;
  logic [MAN_W-1:0]        frac_s;
  logic                    guard_s, sticky_s, round_up_s, inexact_s;
  logic signed [EXP_W+1:0] exp_n_s, exp_f_s;
  logic [W-1:0]            res_s;
  logic [3:0]              flg_s;

  logic         out_valid_r;
  logic [W-1:0] result_r;
  logic [3:0]   flags_r;

  assign en_s          = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;

  assign exp_a_s  = bus.input_a[W-2:MAN_W];
  assign exp_b_s  = bus.input_b[W-2:MAN_W];
  assign frac_a_s = bus.input_a[MAN_W-1:0];
  assign frac_b_s = bus.input_b[MAN_W-1:0];
  assign zero_a_s = (exp_a_s == {EXP_W{1'b0}});
  assign zero_b_s = (exp_b_s == {EXP_W{1'b0}});
  assign inf_a_s  = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s == {MAN_W{1'b0}});
  assign inf_b_s  = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s == {MAN_W{1'b0}});
  assign nan_a_s  = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s != {MAN_W{1'b0}});
  assign nan_b_s  = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s != {MAN_W{1'b0}});
  assign snan_a_s = nan_a_s && !frac_a_s[MAN_W-1];
  assign snan_b_s = nan_b_s && !frac_b_s[MAN_W-1];
  assign exp_sum_s = $signed({2'b00, exp_a_s}) + $signed({2'b00, exp_b_s}) - BIAS_S;

  // Resolve the special-value class up front so later stages only carry a tag
  always_comb begin
    kind_s    = K_NORM;
    invalid_s = 1'b0;
    if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
      kind_s    = K_NAN;
      invalid_s = snan_a_s || snan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s);
    end else if (inf_a_s || inf_b_s) begin
      kind_s = K_INF;
    end else if (zero_a_s || zero_b_s) begin
      kind_s = K_ZERO;
    end else begin
      kind_s = K_NORM;
    end
  end

  // Stage 1: unpacked operands, biased exponent sum and class
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r   <= 1'b0;
      s1_sign_r    <= 1'b0;
      s1_invalid_r <= 1'b0;
      s1_exp_r     <= EXP_ZERO_S;
      s1_man_a_r   <= {(MAN_W+1){1'b0}};
      s1_man_b_r   <= {(MAN_W+1){1'b0}};
      s1_kind_r    <= K_ZERO;
    end else if (en_s) begin
      s1_valid_r   <= bus.in_valid;
      s1_sign_r    <= bus.input_a[W-1] ^ bus.input_b[W-1];
      s1_invalid_r <= invalid_s;
      s1_exp_r     <= exp_sum_s;
      s1_man_a_r   <= {1'b1, frac_a_s};
      s1_man_b_r   <= {1'b1, frac_b_s};
      s1_kind_r    <= kind_s;
    end
  end

  // Stage 2: full-width significand product
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r   <= 1'b0;
      s2_sign_r    <= 1'b0;
      s2_invalid_r <= 1'b0;
      s2_exp_r     <= EXP_ZERO_S;
      s2_prod_r    <= {PW{1'b0}};
      s2_kind_r    <= K_ZERO;
    end else if (en_s) begin
      s2_valid_r   <= s1_valid_r;
      s2_sign_r    <= s1_sign_r;
      s2_invalid_r <= s1_invalid_r;
      s2_exp_r     <= s1_exp_r;
      s2_prod_r    <= PW'(s1_man_a_r) * PW'(s1_man_b_r);
      s2_kind_r    <= s1_kind_r;
    end
  end

  // Normalise, round to nearest-even and apply range limits and specials
  always_comb begin
    mant_s   = s2_prod_r[PW-2:MAN_W];
    guard_s  = s2_prod_r[MAN_W-1];
    sticky_s = |s2_prod_r[MAN_W-2:0];
    exp_n_s  = s2_exp_r;
    if (s2_prod_r[PW-1]) begin
      mant_s   = s2_prod_r[PW-1:MAN_W+1];
      guard_s  = s2_prod_r[MAN_W];
      sticky_s = |s2_prod_r[MAN_W-1:0];
      exp_n_s  = s2_exp_r + EXP_ONE_S;
    end else begin
      exp_n_s  = s2_exp_r;
    end
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    inexact_s  = guard_s | sticky_s;
    mant_rnd_s = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, round_up_s};
    // A carry out leaves exactly 1.0 in the upper bits, so the shifted field is zero
    if (mant_rnd_s[MAN_W+1]) begin
      frac_s  = mant_rnd_s[MAN_W:1];
      exp_f_s = exp_n_s + EXP_ONE_S;
    end else begin
      frac_s  = mant_rnd_s[MAN_W-1:0];
      exp_f_s = exp_n_s;
    end
    res_s = {W{1'b0}};
    flg_s = 4'b0000;
    case (s2_kind_r)
      K_NAN: begin
        res_s = QNAN;
        flg_s = {s2_invalid_r, 3'b000};
      end
      K_INF:  res_s = {s2_sign_r, INF_MAG};
      K_ZERO: res_s = {s2_sign_r, ZERO_MAG};
      K_NORM: begin
        if (exp_f_s >= EXP_MAX_S) begin
          res_s = {s2_sign_r, INF_MAG};
          flg_s = 4'b0101;
        end else if (exp_f_s <= EXP_ZERO_S) begin
          res_s = {s2_sign_r, ZERO_MAG};
          flg_s = 4'b0011;
        end else begin
          res_s = {s2_sign_r, exp_f_s[EXP_W-1:0], frac_s};
          flg_s = {3'b000, inexact_s};
        end
      end
      default: begin
        res_s = {W{1'b0}};
        flg_s = 4'b0000;
      end
    endcase
  end

  // Stage 3: output register, held while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {W{1'b0}};
      flags_r     <= 4'b0000;
    end else if (en_s) begin
      out_valid_r <= s2_valid_r;
      result_r    <= res_s;
      flags_r     <= flg_s;
    end
  end
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench for fp_multiplier_pipe (single precision): directed vectors,
// backpressure, asynchronous reset mid-stream and a randomised handshake run.
module tb_fp_multiplier_pipe;
  logic clk;
  logic reset_n;

  fp_multiplier_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [35:0] exp;
    int          acc;
  } sb_t;

  sb_t  sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  bit   done_r  = 1'b0;

  logic [31:0] vec_a [15];
  logic [31:0] vec_b [15];
  logic [35:0] vec_e [15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the remainder with half an ulp
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, k;
    longint unsigned p, q, rem, half;
    bit s, za, zb, ia, ib, na, nb, sna, snb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    sna = na && !a[22];
    snb = nb && !b[22];
    if (na || nb || (ia && zb) || (za && ib))
      return {(sna || snb || (ia && zb) || (za && ib)), 3'b000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 31'h7F800000};
    if (za || zb) return {4'b0000, s, 31'h00000000};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    k = 0;
    while ((p >> k) >= 64'd16777216) k++;
    q    = p >> k;
    rem  = p - (q << k);
    half = 64'd1 << (k - 1);
    if ((rem > half) || ((rem == half) && q[0])) q++;
    if (q == 64'd16777216) begin
      q = q >> 1;
      k++;
    end
    e = ea + eb - 127 + k - 23;
    if (e >= 255) return {4'b0101, s, 31'h7F800000};
    if (e <= 0)   return {4'b0011, s, 31'h00000000};
    return {3'b000, (rem != 64'd0), s, 8'(e), q[22:0]};
  endfunction

  // Scoreboard and protocol checks, sampled on the falling edge
  initial begin
    bit          prev_stall = 1'b0;
    logic [35:0] prev_out   = 36'd0;
    sb_t         ent;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(bus.out_valid), 64'd1);
          check("stall_data_held", 64'({bus.flags, bus.result}), 64'(prev_out));
        end
        check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (bus.in_valid && bus.in_ready) begin
          ent.exp = model(bus.input_a, bus.input_b);
          ent.acc = cyc;
          sb.push_back(ent);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 64'({bus.flags, bus.result}), 64'hDEAD);
          end else begin
            ent = sb.pop_front();
            check("result", 64'(bus.result), 64'(ent.exp[31:0]));
            check("flags", 64'(bus.flags), 64'(ent.exp[35:32]));
            if (lat_chk) check("latency", 64'(cyc - ent.acc), 64'd3);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = {bus.flags, bus.result};
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    bit acc = 1'b0;
    int g   = 0;
    bus.in_valid = 1'b1;
    bus.input_a  = a;
    bus.input_b  = b;
    while (!acc && g < 1000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp [7];
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC00000; sp[5] = 32'h7F800001;
    sp[6] = 32'h00000001;
    case ($urandom_range(0, 7))
      0: return sp[$urandom_range(0, 6)];
      1: return 32'($urandom);
      2: return {1'($urandom), ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 40))
                                                          : 8'($urandom_range(215, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  initial begin
    vec_a[0]  = 32'h3FC00000; vec_b[0]  = 32'h40000000; vec_e[0]  = {4'b0000, 32'h40400000};
    vec_a[1]  = 32'hC0400000; vec_b[1]  = 32'h40000000; vec_e[1]  = {4'b0000, 32'hC0C00000};
    vec_a[2]  = 32'h3F800001; vec_b[2]  = 32'h3F800001; vec_e[2]  = {4'b0001, 32'h3F800002};
    vec_a[3]  = 32'h3F800000; vec_b[3]  = 32'h3F800000; vec_e[3]  = {4'b0000, 32'h3F800000};
    vec_a[4]  = 32'h7F800000; vec_b[4]  = 32'h00000000; vec_e[4]  = {4'b1000, 32'h7FC00000};
    vec_a[5]  = 32'hFF800000; vec_b[5]  = 32'h40000000; vec_e[5]  = {4'b0000, 32'hFF800000};
    vec_a[6]  = 32'h7FC00001; vec_b[6]  = 32'h3F800000; vec_e[6]  = {4'b0000, 32'h7FC00000};
    vec_a[7]  = 32'h00000001; vec_b[7]  = 32'h7F000000; vec_e[7]  = {4'b0000, 32'h00000000};
    vec_a[8]  = 32'h7F7FFFFF; vec_b[8]  = 32'h40000000; vec_e[8]  = {4'b0101, 32'h7F800000};
    vec_a[9]  = 32'h00800000; vec_b[9]  = 32'h3F000000; vec_e[9]  = {4'b0011, 32'h00000000};
    vec_a[10] = 32'h7F800001; vec_b[10] = 32'h3F800000; vec_e[10] = {4'b1000, 32'h7FC00000};
    vec_a[11] = 32'h3F800001; vec_b[11] = 32'h3FC00000; vec_e[11] = {4'b0001, 32'h3FC00002};
    vec_a[12] = 32'h3F800003; vec_b[12] = 32'h3FC00000; vec_e[12] = {4'b0001, 32'h3FC00004};
    vec_a[13] = 32'h80000000; vec_b[13] = 32'h40A00000; vec_e[13] = {4'b0000, 32'h80000000};
    vec_a[14] = 32'hFF800000; vec_b[14] = 32'h7F800000; vec_e[14] = {4'b0000, 32'hFF800000};

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.input_a   = 32'd0;
    bus.input_b   = 32'd0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_flags", 64'(bus.flags), 64'd0);
    #10 reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 15; i++) check("model_pin", 64'(model(vec_a[i], vec_b[i])), 64'(vec_e[i]));

    // Directed vectors, back to back, with latency checked
    lat_chk = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) drive(vec_a[i], vec_b[i]);
    wait_drain();
    lat_chk = 1'b0;

    // Eight-operand stream with a five-cycle output stall in the middle
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(32'h3F800000 + (32'(i) << 20) + 32'(i), 32'h40100007);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with three operations in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive(32'h3FC00000, 32'h40000000);
    drive(32'h40400000, 32'h40000000);
    drive(32'h3F800001, 32'h3F800001);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_reset_result", 64'(bus.result), 64'd0);
    check("mid_reset_flags", 64'(bus.flags), 64'd0);
    sb.delete();
    #10 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    drive(32'hC0400000, 32'h40000000);
    wait_drain();

    // Random operands and handshakes
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          drive(rnd_op(), rnd_op());
        end
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_multiplier_pipe.md
# fp_multiplier_pipe

- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready flow control.
- Generalises the single-precision combinational-plus-register multiplier:
  - configurable exponent/mantissa widths;
  - round-to-nearest-even;
  - full special-value handling (zero, infinity, NaN);
  - exception flags and backpressure.
- Sits in the arithmetic datapath between operand sources and FP accumulation/result buffers.

## Interface
- `EXP_W`, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- `MAN_W`, 23, stored fraction width (hidden bit implicit).
- `W`, EXP_W+MAN_W+1, derived operand/result width; not overridden.
- `clk` input 1, single clock, rising edge.
- `reset_n` input 1, asynchronous active-low reset.
- `in_valid` input 1, operand pair valid.
- `in_ready` output 1, pipeline accepts operands this cycle.
- `input_a` input W, operand A: {sign, exponent, fraction}.
- `input_b` input W, operand B.
- `out_valid` output 1, result valid.
- `out_ready` input 1, downstream accepts result.
- `result` output W, packed product.
- `flags` output 4, {invalid, overflow, underflow, inexact}, aligned with `result`.

## Operation
- **Stage 1 (unpack/classify):**
  - Split sign, exponent and fraction.
  - Exponent 0 is treated as zero (denormals flushed to zero, regardless of fraction).
  - Exponent all-ones with fraction 0 is infinity; with fraction ≠ 0 it is NaN.
  - Sign = sign_a XOR sign_b.
  - Exponent sum e = exp_a + exp_b - bias, computed signed in EXP_W+2 bits.
- **Stage 2 (multiply):** (MAN_W+1)×(MAN_W+1) unsigned product of {1,frac}, 2·MAN_W+2 bits wide. Class and sign are carried alongside.
- **Stage 3 (normalise/round/pack):**
  - If the product MSB is 1: take the upper MAN_W+1 bits and set e+1. Otherwise shift left by one.
  - Guard = next bit; sticky = OR of the remaining bits.
  - Round to nearest, ties to even: increment if guard & (sticky | lsb).
  - A rounding carry-out renormalises to 1.0 and sets e+1.
  - inexact = guard | sticky.
- **Special-value priority:**
  1. Any NaN input, or inf×zero → canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0. invalid=1 only for inf×zero or a signalling-NaN input (fraction MSB 0).
  2. inf × (nonzero or inf) → signed infinity, no flags.
  3. zero × finite → signed zero, no flags.
  4. Finite, e ≥ all-ones (after rounding) → signed infinity, overflow=1, inexact=1.
  5. Finite, e ≤ 0 (after rounding) → signed zero, underflow=1, inexact=1.
  6. Otherwise → normal packed result, with inexact as computed.
- **Flow control:**
  - Global advance: `en = !out_valid || out_ready`; `in_ready = en`.
  - Each stage holds a valid bit. When en=1, all stages shift and a bubble (valid=0) enters if in_valid=0. When en=0, every stage holds.
  - A transfer occurs on in_valid & in_ready (input side) and on out_valid & out_ready (output side).
  - Results emerge strictly in input order; none is dropped or duplicated.

## Timing
- **Reset (reset_n low, asynchronous):** all stage valids 0, `out_valid`=0, `result`=0, `flags`=0. `in_ready`=1 once reset_n is high.
- **Latency:** exactly 3 cycles from the accepting edge to `out_valid` with `out_ready` held high. Throughput is one result per cycle.
- **Output registers:** `result`/`flags` are registered and stable while out_valid=1 and out_ready=0.
- **Stall release:** when out_ready returns high, the held result transfers that edge and the pipeline advances in the same edge (no bubble inserted).
- **Full pipeline:** at most 3 operations are in flight (stages 1-3) while stalled. in_ready drops combinationally when out_valid=1 and out_ready=0.
- **Reset mid-operation:** in-flight operations are discarded with no partial output. The first post-reset result requires a new accepted input.
- **Simultaneous events:** input accepted and output consumed in the same cycle is legal and required for full throughput.

## Test plan
- **Normal product:** 0x3FC00000 × 0x40000000 (1.5×2.0) → result 0x40400000, flags 0000, out_valid exactly 3 cycles after acceptance. Also 0xC0400000 × 0x40000000 → 0xC0C00000.
- **Rounding:** 0x3F800001 × 0x3F800001 → 0x3F800002, flags 0001 (inexact). 0x3F800000 × 0x3F800000 → 0x3F800000, flags 0000.
- **Special values:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flags 1000.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, flags 0000.
  - 0x00000001 × 0x7F000000 → 0x00000000, flags 0000.
- **Range limits:**
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000, flags 0101.
  - 0x00800000 × 0x3F000000 → 0x00000000, flags 0011.
- **Backpressure:**
  - Stream 8 back-to-back operands with out_ready low for 5 cycles mid-stream.
  - Expect in_ready low while stalled, `result` held stable, all 8 results in order, no loss or duplication.
  - Random out_ready/in_valid for 10k transactions checked against a reference model.
- **Reset mid-stream:** pulse reset_n low for 1 cycle (asynchronous, off-edge) with 3 operations in flight. Expect out_valid=0, result=0, flags=0 immediately, and no stale results after release.
